// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU types for the MEM/WB stage.
//   word_t        : 32-bit machine word.
//   memwb_state_t : data-access sequencer states (IDLE, ACCESS, DONE).
// ---------------------------------------------------------------------------
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no access outstanding; ALU ops pass straight through
    ACCESS = 2'd1,  // request driven to data memory, waiting for dhit
    DONE   = 2'd2   // access complete, result buffered until ihit
  } memwb_state_t;

endpackage

// File: rtl/mem_req_fsm.sv
// ---------------------------------------------------------------------------
// mem_req_fsm
//   Data-memory request sequencer with access-timeout watchdog.
//   Ports:
//     CLK, RST          clock, synchronous active-high reset
//     ihit              pipeline advance qualifier (releases DONE)
//     dhit              data memory access complete
//     start             accept a new access this cycle (valid only in IDLE)
//     is_load/is_store  access type, latched on start
//     state             current sequencer state
//     dmemREN/dmemWEN   memory request, driven only while in ACCESS
//     lat_load          latched "access is a load"
//     err               sticky timeout flag
// ---------------------------------------------------------------------------
module mem_req_fsm
  import cpu_types_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ihit,
  input  logic         dhit,
  input  logic         start,
  input  logic         is_load,
  input  logic         is_store,
  output memwb_state_t state,
  output logic         dmemREN,
  output logic         dmemWEN,
  output logic         lat_load,
  output logic         err
);

  // Counter saturates at WAIT_MAX-1; 8 bits cover the full 2..255 range.
  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  memwb_state_t state_d;
  logic         lat_store;
  logic [7:0]   wait_cnt;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = ACCESS;
      ACCESS:  if (dhit)  state_d = DONE;   // flush never aborts an access
      DONE:    if (ihit)  state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      err       <= 1'b0;
      lat_load  <= 1'b0;
      lat_store <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        lat_load  <= is_load;
        lat_store <= is_store;
        wait_cnt  <= '0;
      end else if (state == ACCESS && !dhit && wait_cnt != CNT_LAST) begin
        wait_cnt <= wait_cnt + 8'd1;
        // err rises on the edge where the count reaches WAIT_MAX-1 and
        // stays set until reset; the request keeps being driven.
        if (wait_cnt == CNT_LAST - 8'd1) err <= 1'b1;
      end
    end
  end

  // Decoded from the registered state: the request first appears the cycle
  // after entry and drops on the edge that leaves ACCESS (including reset).
  assign dmemREN = (state == ACCESS) & lat_load;
  assign dmemWEN = (state == ACCESS) & lat_store;

endmodule

// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe
//   MEM stage data access plus MEM/WB pipeline register.
//   Parameters: PW payload width, DW data width, WAIT_MAX access timeout.
//   Ports:
//     CLK, RST                 clock, synchronous active-high reset
//     ihit, flush              advance qualifier, squash the MEM instruction
//     in_valid, in_payload     EX/MEM instruction
//     in_dren, in_dwen         load / store
//     in_addr, in_store        address (or ALU result), store data
//     dhit, dmemload           data memory completion and load data
//     dmemREN, dmemWEN         data memory request
//     dmemaddr, dmemstore      latched request address / store data
//     mem_stall                MEM cannot advance this cycle
//     out_valid, out_payload   MEM/WB register
//     out_result               load data or ALU result
//     wbEN                     writeback enable (= out_valid)
//     err                      sticky data-access timeout
// ---------------------------------------------------------------------------
module mem_wb_pipe
  import cpu_types_pkg::*;
#(
  parameter int PW       = 64,
  parameter int DW       = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ihit,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [PW-1:0] in_payload,
  input  logic          in_dren,
  input  logic          in_dwen,
  input  logic [DW-1:0] in_addr,
  input  logic [DW-1:0] in_store,
  input  logic          dhit,
  input  logic [DW-1:0] dmemload,
  output logic          dmemREN,
  output logic          dmemWEN,
  output logic [DW-1:0] dmemaddr,
  output logic [DW-1:0] dmemstore,
  output logic          mem_stall,
  output logic          out_valid,
  output logic [PW-1:0] out_payload,
  output logic [DW-1:0] out_result,
  output logic          wbEN,
  output logic          err
);

  memwb_state_t  state;
  logic          lat_load;
  logic          start;
  logic          advance;
  logic          flush_pend;
  logic [DW-1:0] load_buf;

  // A flushed instruction never starts an access; it just drains as invalid.
  assign start     = (state == IDLE) & in_valid & (in_dren | in_dwen) & ~flush;
  assign mem_stall = start | (state == ACCESS) | ((state == DONE) & ~ihit);
  assign advance   = ihit & ~mem_stall;
  assign wbEN      = out_valid;

  mem_req_fsm #(
    .WAIT_MAX (WAIT_MAX)
  ) u_req_fsm (
    .CLK      (CLK),
    .RST      (RST),
    .ihit     (ihit),
    .dhit     (dhit),
    .start    (start),
    .is_load  (in_dren),
    .is_store (in_dwen),
    .state    (state),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .lat_load (lat_load),
    .err      (err)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      dmemaddr    <= '0;
      dmemstore   <= '0;
      flush_pend  <= 1'b0;
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_result  <= '0;
    end else begin
      if (start) begin
        dmemaddr  <= in_addr;
        dmemstore <= in_store;
      end
      if (advance) begin
        out_payload <= in_payload;
        out_valid   <= in_valid & ~flush & ~flush_pend;
        // Only a load that went through DONE returns memory data; stores,
        // ALU ops and dropped accesses forward the address/ALU result.
        out_result  <= (state == DONE && lat_load) ? load_buf : in_addr;
        flush_pend  <= 1'b0;
      end else if (state != IDLE && flush) begin
        // The access runs to completion; remember to squash it on advance.
        flush_pend <= 1'b1;
      end
    end
  end

  // NOTE: load_buf is a pure data holding register with no reset: it is only
  // read in DONE after a load, by which time dhit has always written it.
  always_ff @(posedge CLK) begin
    if (state == ACCESS && dhit && lat_load) load_buf <= dmemload;
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_pipe
//   Self-checking bench for mem_wb_pipe (WAIT_MAX = 4): reset values, a
//   vector table of single-cycle cases, hand-written multi-cycle sequences
//   and a randomized instruction stream against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_mem_wb_pipe;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, flush, in_valid, in_dren, in_dwen, dhit;
  logic [63:0] in_payload;
  word_t       in_addr, in_store, dmemload;
  logic        dmemREN, dmemWEN, mem_stall, out_valid, wbEN, err;
  word_t       dmemaddr, dmemstore, out_result;
  logic [63:0] out_payload;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  mem_wb_pipe #(.PW(64), .DW(32), .WAIT_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload),
    .in_dren(in_dren), .in_dwen(in_dwen),
    .in_addr(in_addr), .in_store(in_store),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .out_valid(out_valid),
    .out_payload(out_payload), .out_result(out_result),
    .wbEN(wbEN), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b0; flush = 1'b0; in_valid = 1'b0; in_dren = 1'b0; in_dwen = 1'b0;
    in_payload = '0; in_addr = '0; in_store = '0; dhit = 1'b0; dmemload = '0;
  endtask

  // Behavioural data memory: unwritten locations read a fixed pattern.
  word_t mem_model [word_t];
  function automatic word_t mem_rd(input word_t a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_0000);
  endfunction

  typedef struct {
    logic        valid, dren, dwen, ihit, flush;
    logic [63:0] payload;
    word_t       addr;
    logic        exp_stall, exp_valid;
    word_t       exp_result;
    logic [63:0] exp_payload;
  } vec_t;
  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single-cycle cases: ALU ops and accesses dropped by flush.
    //            valid dren  dwen  ihit  flush payload  addr           stall valid result          payload
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA0, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_1234, 64'hA0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hA1, 32'h0000_1111, 1'b0, 1'b1, 32'h0000_1234, 64'hA0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'hA2, 32'h0000_2222, 1'b0, 1'b0, 32'h0000_2222, 64'hA2};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA3, 32'h0000_3333, 1'b0, 1'b0, 32'h0000_3333, 64'hA3};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'hA4, 32'h0000_4444, 1'b0, 1'b0, 32'h0000_4444, 64'hA4};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA5, 32'h0000_5555, 1'b0, 1'b1, 32'h0000_5555, 64'hA5};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 64'hA6, 32'h0000_6666, 1'b0, 1'b1, 32'h0000_5555, 64'hA5};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'hA7, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 64'hA7};

    // ---------------- reset ----------------
    idle_inputs();
    RST = 1'b1;
    cyc(); cyc();
    check("rst_out_valid",   out_valid,   0);
    check("rst_wbEN",        wbEN,        0);
    check("rst_out_result",  out_result,  0);
    check("rst_out_payload", out_payload, 0);
    check("rst_dmemREN",     dmemREN,     0);
    check("rst_dmemWEN",     dmemWEN,     0);
    check("rst_dmemaddr",    dmemaddr,    0);
    check("rst_dmemstore",   dmemstore,   0);
    check("rst_err",         err,         0);
    check("rst_mem_stall",   mem_stall,   0);
    RST = 1'b0;

    // ---------------- vector table ----------------
    foreach (vecs[i]) begin
      in_valid = vecs[i].valid; in_dren = vecs[i].dren; in_dwen = vecs[i].dwen;
      ihit = vecs[i].ihit; flush = vecs[i].flush;
      in_payload = vecs[i].payload; in_addr = vecs[i].addr; in_store = $urandom;
      #1;
      check($sformatf("vec%0d_stall", i), mem_stall, vecs[i].exp_stall);
      cyc();
      check($sformatf("vec%0d_valid", i),   out_valid,   vecs[i].exp_valid);
      check($sformatf("vec%0d_wbEN", i),    wbEN,        vecs[i].exp_valid);
      check($sformatf("vec%0d_result", i),  out_result,  vecs[i].exp_result);
      check($sformatf("vec%0d_payload", i), out_payload, vecs[i].exp_payload);
      check($sformatf("vec%0d_noreq", i),   dmemREN | dmemWEN, 0);
    end
    idle_inputs();

    // ---------------- load, dhit two cycles after request, ihit held ----------------
    in_valid = 1'b1; in_dren = 1'b1; in_addr = 32'h40; in_payload = 64'hB0; ihit = 1'b1;
    #1;
    check("ld_entry_stall", mem_stall, 1);
    check("ld_entry_noreq", dmemREN, 0);
    cyc();
    check("ld_req", dmemREN, 1);
    check("ld_addr", dmemaddr, 32'h40);
    check("ld_acc1_stall", mem_stall, 1);
    cyc();
    check("ld_acc2_req", dmemREN, 1);
    cyc();
    dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
    #1;
    check("ld_dhit_ihit_stall", mem_stall, 1);
    cyc();
    dhit = 1'b0; dmemload = '0;
    check("ld_done_noreq", dmemREN, 0);
    check("ld_no_early_adv", out_result, 32'hFFFF_FFFF);
    #1;
    check("ld_done_stall", mem_stall, 0);
    cyc();
    check("ld_result",  out_result,  32'hDEAD_BEEF);
    check("ld_valid",   out_valid,   1);
    check("ld_wbEN",    wbEN,        1);
    check("ld_payload", out_payload, 64'hB0);
    idle_inputs();

    // ---------------- store 0x80 <- 0x55 ----------------
    in_valid = 1'b1; in_dwen = 1'b1; in_addr = 32'h80; in_store = 32'h55; in_payload = 64'hC0;
    cyc();
    in_store = 32'h99;  // upstream data changing must not disturb the request
    check("st_wen", dmemWEN, 1);
    check("st_ren", dmemREN, 0);
    check("st_addr", dmemaddr, 32'h80);
    check("st_data", dmemstore, 32'h55);
    cyc();
    check("st_wen_held", dmemWEN, 1);
    check("st_data_held", dmemstore, 32'h55);
    dhit = 1'b1; dmemload = 32'hBAD0_BAD0;
    cyc();
    dhit = 1'b0;
    check("st_done_nowen", dmemWEN, 0);
    ihit = 1'b1;
    cyc();
    check("st_result", out_result, 32'h80);
    check("st_valid", out_valid, 1);
    idle_inputs();

    // ---------------- flush during ACCESS ----------------
    in_valid = 1'b1; in_dren = 1'b1; in_addr = 32'h44; in_payload = 64'hD0;
    cyc();
    flush = 1'b1;
    check("fl_req", dmemREN, 1);
    cyc();
    flush = 1'b0;
    check("fl_not_aborted", dmemREN, 1);
    dhit = 1'b1; dmemload = 32'h1234_5678;
    cyc();
    dhit = 1'b0; ihit = 1'b1;
    cyc();
    check("fl_valid", out_valid, 0);
    check("fl_wbEN", wbEN, 0);
    // Next ALU op must not inherit the squash; a stray dhit in IDLE is ignored.
    in_dren = 1'b0; in_addr = 32'h77; in_payload = 64'hD1;
    dhit = 1'b1; dmemload = 32'hBAAD_F00D;
    #1;
    check("fl_next_stall", mem_stall, 0);
    cyc();
    check("fl_next_valid", out_valid, 1);
    check("fl_next_result", out_result, 32'h77);
    check("stray_dhit_noreq", dmemREN | dmemWEN, 0);
    idle_inputs();

    // ---------------- DONE holds while ihit low ----------------
    in_valid = 1'b1; in_dren = 1'b1; in_addr = 32'h48; in_payload = 64'hE0;
    cyc();
    dhit = 1'b1; dmemload = 32'hCAFE_F00D;
    cyc();
    dhit = 1'b0; dmemload = '0;
    for (int k = 0; k < 5; k++) begin
      check("hold_result", out_result, 32'h77);
      check("hold_valid", out_valid, 1);
      check("hold_payload", out_payload, 64'hD1);
      check("hold_noreq", dmemREN, 0);
      check("hold_stall", mem_stall, 1);
      cyc();
    end
    ihit = 1'b1;
    #1;
    check("hold_release_stall", mem_stall, 0);
    cyc();
    check("hold_result_final", out_result, 32'hCAFE_F00D);
    check("hold_payload_final", out_payload, 64'hE0);
    idle_inputs();

    // ---------------- randomized stream vs transaction model ----------------
    for (int n = 0; n < 300; n++) begin
      int          kind, fl_mode, wait_left, cycles;
      logic        ld, st, v, fl0, fl_late, access, saw_req, dhit_done, dhit_before;
      logic        retired, req, adv, exp_valid;
      word_t       a, sd, exp_res;
      logic [63:0] pl;
      kind    = $urandom_range(0, 2);
      ld      = (kind == 1);
      st      = (kind == 2);
      v       = ($urandom_range(0, 9) != 0);
      a       = 32'($urandom_range(0, 7)) << 2;
      sd      = $urandom;
      pl      = {$urandom, $urandom};
      fl_mode = $urandom_range(0, 5);
      fl0     = (fl_mode == 0);
      access  = v & (ld | st) & ~fl0;
      fl_late = (fl_mode == 1) & access;
      wait_left = $urandom_range(0, 2);
      exp_res   = a;
      exp_valid = v & ~fl0 & ~fl_late;
      cycles = 0; retired = 1'b0; saw_req = 1'b0; dhit_done = 1'b0;
      while (!retired && cycles < 40) begin
        req = dmemREN | dmemWEN;
        dhit_before = dhit_done;
        in_valid = v; in_dren = ld; in_dwen = st; in_addr = a; in_store = sd; in_payload = pl;
        ihit  = (fl0 && cycles == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        flush = (fl0 && cycles == 0) || (fl_late && req && !saw_req);
        if (req) begin
          if (!saw_req) begin
            check("rnd_req_addr", dmemaddr, a);
            check("rnd_req_type", {dmemREN, dmemWEN}, {ld, st});
            if (st) check("rnd_req_data", dmemstore, sd);
          end
          saw_req = 1'b1;
          if (wait_left == 0) begin
            dhit = 1'b1;
            dmemload = mem_rd(a);
            if (ld) exp_res = mem_rd(a);
            if (st) mem_model[a] = sd;
            dhit_done = 1'b1;
          end else begin
            wait_left--;
            dhit = 1'b0;
            dmemload = $urandom;
          end
        end else begin
          dhit = ($urandom_range(0, 3) == 0);
          dmemload = $urandom;
        end
        #1;
        if (req) check("rnd_stall_in_access", mem_stall, 1);
        if (cycles == 0) check("rnd_entry_stall", mem_stall, access);
        adv = ihit & ~mem_stall;
        cyc();
        cycles++;
        if (adv) begin
          retired = 1'b1;
          if (access) check("rnd_adv_after_dhit", dhit_before, 1);
          check("rnd_valid",   out_valid,   exp_valid);
          check("rnd_wbEN",    wbEN,        exp_valid);
          check("rnd_result",  out_result,  exp_res);
          check("rnd_payload", out_payload, pl);
        end
      end
      if (!retired) check("rnd_retire_timeout", 0, 1);
      check("rnd_access_seen", saw_req, access);
    end
    check("rnd_no_err", err, 0);
    idle_inputs();

    // ---------------- timeout with WAIT_MAX = 4, then reset mid-ACCESS ----------------
    in_valid = 1'b1; in_dren = 1'b1; in_addr = 32'h50; in_payload = 64'hF0;
    cyc();          // now in ACCESS
    cyc(); cyc();   // two ACCESS cycles without dhit
    check("err_not_yet", err, 0);
    cyc();          // third ACCESS cycle without dhit
    check("err_set", err, 1);
    check("err_req_held", dmemREN, 1);
    cyc(); cyc();
    check("err_sticky", err, 1);
    check("err_still_access", dmemREN, 1);
    idle_inputs();
    RST = 1'b1;
    cyc();
    check("rst2_err", err, 0);
    check("rst2_ren", dmemREN, 0);
    check("rst2_valid", out_valid, 0);
    check("rst2_result", out_result, 0);
    check("rst2_dmemaddr", dmemaddr, 0);
    check("rst2_stall", mem_stall, 0);
    RST = 1'b0;
    cyc();
    check("rst2_idle_noreq", dmemREN | dmemWEN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
